// File: rtl/mini_cpu_pipe.sv
`default_nettype none
// =============================================================================
// mini_cpu_pipe : sequenced mini CPU (IDLE -> EXEC -> WB), one instruction per
// three cycles against a WIDTH x NREGS register file. Optional build macro:
// MINI_CPU_SAT_EN (saturating ADD/SUB).                         Revision 1.0
// =============================================================================

module mini_cpu_pipe #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS),
  localparam int IW    = 4 + 2*AW + WIDTH
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic [IW-1:0]    instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_CLR = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_MOV = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  // EXEC -> WB pipeline register
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;
  logic             wr_q, wr_d;
  logic             upd_out_q, upd_out_d;
  logic             upd_ovf_q, upd_ovf_d;
  logic             clr_all_q, clr_all_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  // Decode from the latched word; it stays stable through EXEC and WB.
  logic [3:0]       op;
  logic [AW-1:0]    rd_a, rs_a;
  logic [WIDTH-1:0] imm, a, b;
  logic [WIDTH:0]   sum, diff;

  assign op   = ir_q[IW-1 -: 4];
  assign rd_a = ir_q[WIDTH+2*AW-1 -: AW];
  assign rs_a = ir_q[WIDTH+AW-1 -: AW];
  assign imm  = ir_q[WIDTH-1:0];
  assign a    = regs_q[rd_a];
  assign b    = regs_q[rs_a];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    res_d       = res_q;
    flag_d      = flag_q;
    wr_d        = wr_q;
    upd_out_d   = upd_out_q;
    upd_ovf_d   = upd_ovf_q;
    clr_all_d   = clr_all_q;
    ill_d       = ill_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    illegal_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        res_d     = '0;
        flag_d    = 1'b0;
        wr_d      = 1'b0;
        upd_out_d = 1'b0;
        upd_ovf_d = 1'b0;
        clr_all_d = 1'b0;
        ill_d     = 1'b0;
        case (op)
          OP_NOP: ;
          OP_CLR: begin
            clr_all_d = 1'b1;
          end
          OP_LDI: begin
            res_d = imm; wr_d = 1'b1; upd_out_d = 1'b1;
          end
          OP_ADD: begin
`ifdef MINI_CPU_SAT_EN
            res_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
            res_d = sum[WIDTH-1:0];
`endif
            flag_d = sum[WIDTH]; wr_d = 1'b1; upd_out_d = 1'b1; upd_ovf_d = 1'b1;
          end
          OP_SUB: begin
            // diff[WIDTH] is the borrow, i.e. rs > rd unsigned
`ifdef MINI_CPU_SAT_EN
            res_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
            res_d = diff[WIDTH-1:0];
`endif
            flag_d = diff[WIDTH]; wr_d = 1'b1; upd_out_d = 1'b1; upd_ovf_d = 1'b1;
          end
          OP_SHL: begin
            res_d = a << 1; flag_d = a[WIDTH-1];
            wr_d = 1'b1; upd_out_d = 1'b1; upd_ovf_d = 1'b1;
          end
          OP_SHR: begin
            res_d = a >> 1; flag_d = a[0];
            wr_d = 1'b1; upd_out_d = 1'b1; upd_ovf_d = 1'b1;
          end
          OP_AND: begin
            res_d = a & b; wr_d = 1'b1; upd_out_d = 1'b1; upd_ovf_d = 1'b1;
          end
          OP_OR: begin
            res_d = a | b; wr_d = 1'b1; upd_out_d = 1'b1; upd_ovf_d = 1'b1;
          end
          OP_CMP: begin
            res_d[2:0] = {a < b, a == b, a > b};
            upd_out_d  = 1'b1; upd_ovf_d = 1'b1;
          end
          OP_OUT: begin
            res_d = a; upd_out_d = 1'b1;
          end
          OP_MOV: begin
            res_d = b; wr_d = 1'b1; upd_out_d = 1'b1;
          end
          default: begin
            ill_d = 1'b1;
          end
        endcase
        state_d = S_WB;
      end

      S_WB: begin
        if (clr_all_q) begin
          for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
          out_d       = '0;
          overflow_d  = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          if (wr_q) regs_d[rd_a] = res_q;
          if (upd_out_q) begin
            out_d       = res_q;
            out_valid_d = 1'b1;
          end
          if (upd_ovf_q) overflow_d = flag_q;
          illegal_d = ill_q;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      res_q       <= '0;
      flag_q      <= 1'b0;
      wr_q        <= 1'b0;
      upd_out_q   <= 1'b0;
      upd_ovf_q   <= 1'b0;
      clr_all_q   <= 1'b0;
      ill_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      res_q       <= res_d;
      flag_q      <= flag_d;
      wr_q        <= wr_d;
      upd_out_q   <= upd_out_d;
      upd_ovf_q   <= upd_ovf_d;
      clr_all_q   <= clr_all_d;
      ill_q       <= ill_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign overflow    = overflow_q;
  assign illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_mini_cpu_pipe.sv
`default_nettype none
// =============================================================================
// tb_mini_cpu_pipe : directed vector table plus back-to-back and mid-instruction
// reset sequences for mini_cpu_pipe (WIDTH=8, NREGS=4).          Revision 1.0
// =============================================================================

module tb_mini_cpu_pipe;

  localparam logic [3:0] NOP = 4'h0, CLR = 4'h1, LDI = 4'h2, ADD = 4'h3;
  localparam logic [3:0] SUB = 4'h4, SHL = 4'h5, SHR = 4'h6, AND = 4'h7;
  localparam logic [3:0] OR_ = 4'h8, CMP = 4'h9, OUT = 4'hA, MOV = 4'hB;

`ifdef MINI_CPU_SAT_EN
  localparam logic [7:0] ADD_EXP = 8'hFF;
  localparam logic [7:0] SUB_EXP = 8'h00;
  localparam logic [7:0] CMP_EXP = 8'h04;  // r2 saturated to 0 -> lt (bit2)
`else
  localparam logic [7:0] ADD_EXP = 8'h2C;
  localparam logic [7:0] SUB_EXP = 8'hFC;
  localparam logic [7:0] CMP_EXP = 8'h01;  // 0xFC > 0x09 -> gt (bit0)
`endif

  logic        clock;
  logic        clr_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        overflow;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [15:0] ins;
    logic        ev;
    logic        ei;
    logic [7:0]  eo;
    logic        eovf;
  } vec_t;

  vec_t vt[$];

  mini_cpu_pipe #(.WIDTH(8), .NREGS(4)) dut (
    .clock       (clock),
    .clr_n       (clr_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .out         (out),
    .out_valid   (out_valid),
    .overflow    (overflow),
    .illegal     (illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [15:0] ins, input logic ev,
                     input logic ei, input logic [7:0] eo, input logic eovf);
    vec_t v;
    v.nm = nm; v.ins = ins; v.ev = ev; v.ei = ei; v.eo = eo; v.eovf = eovf;
    vt.push_back(v);
  endtask

  // Called at a negedge; returns at a negedge with instr_ready high or reports a timeout.
  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) chk({nm, " ready timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int nv, ni, lat;
    wait_ready(v.nm);
    instr = v.ins;
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    nv = 0; ni = 0; lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (out_valid) begin nv++; lat = c; end
      if (illegal) begin ni++; lat = c; end
    end
    chk({v.nm, " out_valid pulses"}, nv, {31'd0, v.ev});
    chk({v.nm, " illegal pulses"}, ni, {31'd0, v.ei});
    if (v.ev || v.ei) chk({v.nm, " latency"}, lat, 32'd3);
    chk({v.nm, " out"}, {24'd0, out}, {24'd0, v.eo});
    chk({v.nm, " overflow"}, {31'd0, overflow}, {31'd0, v.eovf});
  endtask

  initial begin
    logic [15:0] q [4];
    logic [7:0]  qexp [4];
    logic [7:0]  got [$];
    int          acc_cyc [4];
    int          idx, npulse, cyc, extra;
    logic        acc;
    vec_t        v;

    add("LDI r0,C8",  mk(LDI, 0, 0, 8'hC8), 1, 0, 8'hC8, 0);
    add("LDI r1,64",  mk(LDI, 1, 0, 8'h64), 1, 0, 8'h64, 0);
    add("ADD r0,r1",  mk(ADD, 0, 1, 8'h00), 1, 0, ADD_EXP, 1);
    add("LDI r2,05",  mk(LDI, 2, 0, 8'h05), 1, 0, 8'h05, 1);
    add("LDI r3,09",  mk(LDI, 3, 0, 8'h09), 1, 0, 8'h09, 1);
    add("SUB r2,r3",  mk(SUB, 2, 3, 8'h00), 1, 0, SUB_EXP, 1);
    add("CMP r2,r3",  mk(CMP, 2, 3, 8'h00), 1, 0, CMP_EXP, 0);
    add("LDI r1,81",  mk(LDI, 1, 0, 8'h81), 1, 0, 8'h81, 0);
    add("SHL r1",     mk(SHL, 1, 0, 8'h00), 1, 0, 8'h02, 1);
    add("SHR r1",     mk(SHR, 1, 0, 8'h00), 1, 0, 8'h01, 0);
    add("OUT r1",     mk(OUT, 1, 0, 8'h00), 1, 0, 8'h01, 0);
    add("ADD r1,r1",  mk(ADD, 1, 1, 8'h00), 1, 0, 8'h02, 0);
    add("MOV r0,r1",  mk(MOV, 0, 1, 8'h00), 1, 0, 8'h02, 0);
    add("AND r3,r0",  mk(AND, 3, 0, 8'h00), 1, 0, 8'h00, 0);
    add("OR r3,r0",   mk(OR_, 3, 0, 8'h00), 1, 0, 8'h02, 0);
    add("OUT r0",     mk(OUT, 0, 0, 8'h00), 1, 0, 8'h02, 0);
    add("LDI r3,80",  mk(LDI, 3, 0, 8'h80), 1, 0, 8'h80, 0);
    add("SHL r3",     mk(SHL, 3, 0, 8'h00), 1, 0, 8'h00, 1);
    add("ILL D",      mk(4'hD, 1, 2, 8'h55), 0, 1, 8'h00, 1);
    add("NOP",        mk(NOP, 1, 0, 8'h77), 0, 0, 8'h00, 1);
    add("OUT r1 post-ill", mk(OUT, 1, 0, 8'h00), 1, 0, 8'h02, 1);
    add("CLR",        mk(CLR, 0, 0, 8'h00), 1, 0, 8'h00, 0);
    add("OUT r0 clr", mk(OUT, 0, 0, 8'h00), 1, 0, 8'h00, 0);
    add("OUT r1 clr", mk(OUT, 1, 0, 8'h00), 1, 0, 8'h00, 0);
    add("OUT r2 clr", mk(OUT, 2, 0, 8'h00), 1, 0, 8'h00, 0);
    add("OUT r3 clr", mk(OUT, 3, 0, 8'h00), 1, 0, 8'h00, 0);

    instr = '0;
    instr_valid = 1'b0;
    clr_n = 1'b0;
    repeat (3) @(negedge clock);
    clr_n = 1'b1;
    @(negedge clock);
    chk("reset out",       {24'd0, out},         32'd0);
    chk("reset out_valid", {31'd0, out_valid},   32'd0);
    chk("reset overflow",  {31'd0, overflow},    32'd0);
    chk("reset illegal",   {31'd0, illegal},     32'd0);
    chk("reset ready",     {31'd0, instr_ready}, 32'd1);

    foreach (vt[i]) run_vec(vt[i]);

    // Back-to-back: instr_valid held high across four queued LDIs.
    for (int i = 0; i < 4; i++) begin
      qexp[i] = 8'h11 * 8'(i + 1);
      q[i]    = mk(LDI, 2'(i), 2'd0, qexp[i]);
    end
    idx = 0; npulse = 0; cyc = 0;
    while (cyc < 40 && (idx < 4 || npulse < 4)) begin
      if (out_valid) begin got.push_back(out); npulse++; end
      if (idx < 4) begin instr = q[idx]; instr_valid = 1'b1; end
      else instr_valid = 1'b0;
      acc = instr_ready && instr_valid;
      if (acc) acc_cyc[idx] = cyc;
      @(posedge clock);
      if (acc) idx++;
      @(negedge clock);
      cyc++;
    end
    instr_valid = 1'b0;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) extra++;
      @(negedge clock);
    end
    chk("b2b accepted", idx, 32'd4);
    chk("b2b pulses", npulse + extra, 32'd4);
    for (int i = 1; i < 4; i++) chk($sformatf("b2b accept gap %0d", i),
                                    acc_cyc[i] - acc_cyc[i-1], 32'd3);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b value %0d", i),
          (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, {24'd0, qexp[i]});

    // Reset asserted while ADD sits in EXEC.
    v.nm = "LDI r0,AA"; v.ins = mk(LDI, 0, 0, 8'hAA); v.ev = 1; v.ei = 0; v.eo = 8'hAA; v.eovf = 0;
    run_vec(v);
    v.nm = "SHL r0"; v.ins = mk(SHL, 0, 0, 8'h00); v.ev = 1; v.ei = 0; v.eo = 8'h54; v.eovf = 1;
    run_vec(v);
    wait_ready("abort ADD");
    instr = mk(ADD, 0, 0, 8'h00);
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    #1 clr_n = 1'b0;
    #1;
    chk("abort out",       {24'd0, out},         32'd0);
    chk("abort overflow",  {31'd0, overflow},    32'd0);
    chk("abort out_valid", {31'd0, out_valid},   32'd0);
    chk("abort ready",     {31'd0, instr_ready}, 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    clr_n = 1'b1;
    @(negedge clock);
    chk("abort no late pulse", {31'd0, out_valid}, 32'd0);
    v.nm = "OUT r0 after abort"; v.ins = mk(OUT, 0, 0, 8'h00); v.ev = 1; v.ei = 0; v.eo = 8'h00; v.eovf = 0;
    run_vec(v);
    v.nm = "OUT r1 after abort"; v.ins = mk(OUT, 1, 0, 8'h00);
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
